pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_seq_pkg.sv | 40 ++++
 rtl/pc_sequencer_if.sv | 31 +++
 rtl/pc_seq_next_mux.sv | 67 ++++++
 rtl/pc_sequencer.sv | 121 ++++++++++++
 tb/tb_pc_sequencer.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the PC sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pc_seq_pkg;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    ST_BOOT       = 2'd0,
    ST_RUN        = 2'd1,
    ST_TRAP_ENTRY = 2'd2,
    ST_HALT       = 2'd3
  } state_e;

  // Trap cause codes as seen on trap_cause
  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_EXT      = 2'd1,
    CAUSE_MISALIGN = 2'd2
  } cause_e;

  // Which source the next-PC mux picked in RUN
  typedef enum logic [2:0] {
    SEL_HOLD   = 3'd0,
    SEL_SEQ    = 3'd1,
    SEL_BRANCH = 3'd2,
    SEL_MRET   = 3'd3,
    SEL_TRAP   = 3'd4,
    SEL_HALT   = 3'd5
  } sel_e;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;
  localparam int unsigned DEF_INSTR_BYTES  = 4;

  // Instruction addresses must be word aligned
  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch/redirect/trap bundle between the PC sequencer and its surroundings.
// Latency: n/a (wires only).
// Backpressure: fetch_ready from the instruction memory, stall from the pipeline.
interface pc_sequencer_if;
  logic [31:0] pc_current;
  logic [31:0] pc_next;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_addr;
  logic        stall;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic        trap_req;
  logic        mret;
  logic [31:0] epc;
  logic [1:0]  trap_cause;
  logic        trap_active;
  logic        halted;

  // Sequencer side: produces the next PC and the fetch request
  modport master (
    input  pc_current, fetch_ready, stall, branch_valid, branch_target, trap_req, mret,
    output pc_next, fetch_valid, fetch_addr, epc, trap_cause, trap_active, halted
  );

  // Environment side: PC register, instruction memory, pipeline control
  modport slave (
    output pc_current, fetch_ready, stall, branch_valid, branch_target, trap_req, mret,
    input  pc_next, fetch_valid, fetch_addr, epc, trap_cause, trap_active, halted
  );
endinterface

// File: rtl/pc_seq_next_mux.sv
// Next-PC priority select for the RUN state: trap > mret > branch > sequential > hold.
// Latency: purely combinational, zero cycles.
// Backpressure: sequential advance only on fetch handshake without stall; redirects ignore both.
module pc_seq_next_mux
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] TRAP_VECTOR = DEF_TRAP_VECTOR,
  parameter int unsigned INSTR_BYTES = DEF_INSTR_BYTES
) (
  input  logic [31:0] pc_current_i,
  input  logic [31:0] epc_i,
  input  logic [31:0] branch_target_i,
  input  logic        fetch_valid_i,
  input  logic        fetch_ready_i,
  input  logic        stall_i,
  input  logic        branch_valid_i,
  input  logic        trap_req_i,
  input  logic        mret_i,
  input  logic        trap_active_i,
  output sel_e        sel_o,
  output logic [31:0] pc_next_o,
  output cause_e      cause_o
);

  localparam logic [31:0] INC = 32'(INSTR_BYTES);

  logic take_trap;

  // Pick the redirect source; a misaligned branch becomes a trap at branch priority
  always_comb begin
    sel_o     = SEL_HOLD;
    pc_next_o = pc_current_i;
    cause_o   = CAUSE_NONE;
    take_trap = 1'b0;

    if (trap_req_i) begin
      take_trap = 1'b1;
      cause_o   = CAUSE_EXT;
    end else if (mret_i && trap_active_i) begin
      sel_o     = SEL_MRET;
      pc_next_o = epc_i + INC;
    end else if (branch_valid_i) begin
      if (is_misaligned(branch_target_i)) begin
        take_trap = 1'b1;
        cause_o   = CAUSE_MISALIGN;
      end else begin
        sel_o     = SEL_BRANCH;
        pc_next_o = branch_target_i;
      end
    end else if (fetch_valid_i && fetch_ready_i && !stall_i) begin
      sel_o     = SEL_SEQ;
      pc_next_o = pc_current_i + INC;
    end

    // A trap inside the handler is a double fault: freeze the PC instead of vectoring
    if (take_trap) begin
      if (trap_active_i) begin
        sel_o     = SEL_HALT;
        pc_next_o = pc_current_i;
      end else begin
        sel_o     = SEL_TRAP;
        pc_next_o = TRAP_VECTOR;
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: boot, sequential fetch, branch redirect, trap entry/return, double-fault halt.
// Latency: pc_next/fetch_valid/fetch_addr combinational (zero cycles); trap status registered (one cycle).
// Backpressure: PC holds while fetch_ready=0 or stall=1; branch/trap/mret redirect regardless.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] TRAP_VECTOR  = DEF_TRAP_VECTOR,
  parameter int unsigned INSTR_BYTES  = DEF_INSTR_BYTES
) (
  input logic            clk,
  input logic            reset,
  pc_sequencer_if.master bus
);

  state_e      state_q, state_d;
  logic [31:0] epc_q, epc_d;
  cause_e      cause_q, cause_d;
  logic        active_q, active_d;
  logic        halted_q, halted_d;

  logic        fetch_valid_c;
  logic [31:0] pc_next_c;
  logic        run_c;

  sel_e        run_sel;
  logic [31:0] run_pc;
  cause_e      run_cause;

  // Only RUN issues fetches; computed from state alone so the mux sees no loop
  assign run_c = (state_q == ST_RUN);

  pc_seq_next_mux #(
    .TRAP_VECTOR (TRAP_VECTOR),
    .INSTR_BYTES (INSTR_BYTES)
  ) u_next_mux (
    .pc_current_i    (bus.pc_current),
    .epc_i           (epc_q),
    .branch_target_i (bus.branch_target),
    .fetch_valid_i   (run_c),
    .fetch_ready_i   (bus.fetch_ready),
    .stall_i         (bus.stall),
    .branch_valid_i  (bus.branch_valid),
    .trap_req_i      (bus.trap_req),
    .mret_i          (bus.mret),
    .trap_active_i   (active_q),
    .sel_o           (run_sel),
    .pc_next_o       (run_pc),
    .cause_o         (run_cause)
  );

  // Next state, trap bookkeeping and the combinational fetch outputs
  always_comb begin
    state_d       = state_q;
    epc_d         = epc_q;
    cause_d       = cause_q;
    active_d      = active_q;
    halted_d      = halted_q;
    pc_next_c     = bus.pc_current;
    fetch_valid_c = 1'b0;

    case (state_q)
      ST_BOOT: begin
        pc_next_c = RESET_VECTOR;
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        fetch_valid_c = 1'b1;
        pc_next_c     = run_pc;
        case (run_sel)
          SEL_TRAP: begin
            epc_d    = bus.pc_current;
            cause_d  = run_cause;
            active_d = 1'b1;
            state_d  = ST_TRAP_ENTRY;
          end
          SEL_HALT: begin
            halted_d = 1'b1;
            state_d  = ST_HALT;
          end
          SEL_MRET: begin
            active_d = 1'b0;
            cause_d  = CAUSE_NONE;
          end
          default: ;
        endcase
      end
      // One bubble while the handler address lands in the PC register
      ST_TRAP_ENTRY: state_d = ST_RUN;
      // Frozen until reset
      ST_HALT: ;
      default: state_d = ST_BOOT;
    endcase
  end

  // State and trap status registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_BOOT;
      epc_q    <= 32'h0;
      cause_q  <= CAUSE_NONE;
      active_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      epc_q    <= epc_d;
      cause_q  <= cause_d;
      active_q <= active_d;
      halted_q <= halted_d;
    end
  end

  assign bus.pc_next     = pc_next_c;
  assign bus.fetch_valid = fetch_valid_c;
  assign bus.fetch_addr  = bus.pc_current;
  assign bus.epc         = epc_q;
  assign bus.trap_cause  = cause_q;
  assign bus.trap_active = active_q;
  assign bus.halted      = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: per-cycle expectations queued by the driver, compared at negedge.
// Latency: n/a.
// Backpressure: exercised through stall and fetch_ready in the stimulus.
module tb_pc_sequencer;

  logic clk;
  logic reset;
  logic [31:0] pc_q;

  pc_sequencer_if bus ();

  pc_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       tag;
    logic        fv;
    logic [31:0] fa;
    logic [31:0] pn;
    logic        ta;
    logic [1:0]  tc;
    logic [31:0] epc;
    logic        hl;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ProgramCounter register; odd reset value so RESET_VECTOR on pc_next is distinguishable
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc_q <= 32'hDEAD_BEE0;
    else        pc_q <= bus.pc_next;
  end
  assign bus.pc_current = pc_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // Queue this cycle's expected outputs, then advance one clock and drop the pulses
  task automatic expect_cyc(input string tag, input logic fv, input logic [31:0] fa,
                            input logic [31:0] pn, input logic ta, input logic [1:0] tc,
                            input logic [31:0] epc, input logic hl);
    exp_t e;
    e.tag = tag; e.fv = fv; e.fa = fa; e.pn = pn;
    e.ta = ta; e.tc = tc; e.epc = epc; e.hl = hl;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.branch_valid = 1'b0;
    bus.trap_req     = 1'b0;
    bus.mret         = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".pn"},  bus.pc_next,            32'h0);
    check({tag, ".fv"},  32'(bus.fetch_valid),   32'h0);
    check({tag, ".fa"},  bus.fetch_addr,         32'hDEAD_BEE0);
    check({tag, ".epc"}, bus.epc,                32'h0);
    check({tag, ".tc"},  32'(bus.trap_cause),    32'h0);
    check({tag, ".ta"},  32'(bus.trap_active),   32'h0);
    check({tag, ".hl"},  32'(bus.halted),        32'h0);
  endtask

  // Scoreboard compare away from the active edge
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check($sformatf("%s.fv", e.tag),  32'(bus.fetch_valid), 32'(e.fv));
      check($sformatf("%s.fa", e.tag),  bus.fetch_addr,       e.fa);
      check($sformatf("%s.pn", e.tag),  bus.pc_next,          e.pn);
      check($sformatf("%s.ta", e.tag),  32'(bus.trap_active), 32'(e.ta));
      check($sformatf("%s.tc", e.tag),  32'(bus.trap_cause),  32'(e.tc));
      check($sformatf("%s.epc", e.tag), bus.epc,              e.epc);
      check($sformatf("%s.hl", e.tag),  32'(bus.halted),      32'(e.hl));
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset             = 1'b0;
    bus.fetch_ready   = 1'b1;
    bus.stall         = 1'b0;
    bus.branch_valid  = 1'b0;
    bus.branch_target = 32'h0;
    bus.trap_req      = 1'b0;
    bus.mret          = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_reset_values("rst_init");
    reset = 1'b1;

    // Boot bubble then sequential fetch with a 3-cycle stall at 8
    expect_cyc("boot",     0, 32'hDEAD_BEE0, 32'h0,  0, 0, 32'h0, 0);
    expect_cyc("seq0",     1, 32'h0,   32'h4,   0, 0, 32'h0, 0);
    expect_cyc("seq4",     1, 32'h4,   32'h8,   0, 0, 32'h0, 0);
    bus.stall = 1'b1;
    expect_cyc("stall1",   1, 32'h8,   32'h8,   0, 0, 32'h0, 0);
    expect_cyc("stall2",   1, 32'h8,   32'h8,   0, 0, 32'h0, 0);
    expect_cyc("stall3",   1, 32'h8,   32'h8,   0, 0, 32'h0, 0);
    bus.stall = 1'b0;
    expect_cyc("seq8",     1, 32'h8,   32'hC,   0, 0, 32'h0, 0);

    // Misaligned branch at C traps with cause 2
    bus.branch_valid = 1'b1; bus.branch_target = 32'h42;
    expect_cyc("mis_br",   1, 32'hC,   32'h100, 0, 0, 32'h0, 0);
    expect_cyc("tentry1",  0, 32'h100, 32'h100, 1, 2, 32'hC, 0);
    // mret beats a simultaneous branch
    bus.mret = 1'b1; bus.branch_valid = 1'b1; bus.branch_target = 32'h80;
    expect_cyc("mret1",    1, 32'h100, 32'h10,  1, 2, 32'hC, 0);

    // External trap at 10, hold in handler, return to 14
    bus.trap_req = 1'b1;
    expect_cyc("trap10",   1, 32'h10,  32'h100, 0, 0, 32'hC, 0);
    expect_cyc("tentry2",  0, 32'h100, 32'h100, 1, 1, 32'h10, 0);
    bus.fetch_ready = 1'b0;
    expect_cyc("hdl_hold", 1, 32'h100, 32'h100, 1, 1, 32'h10, 0);
    bus.fetch_ready = 1'b1; bus.mret = 1'b1;
    expect_cyc("mret2",    1, 32'h100, 32'h14,  1, 1, 32'h10, 0);

    // Branch back to C, then branch to 40 despite stall and no ready
    bus.branch_valid = 1'b1; bus.branch_target = 32'hC;
    expect_cyc("br_c",     1, 32'h14,  32'hC,   0, 0, 32'h10, 0);
    bus.fetch_ready = 1'b0; bus.stall = 1'b1;
    bus.branch_valid = 1'b1; bus.branch_target = 32'h40;
    expect_cyc("br_40",    1, 32'hC,   32'h40,  0, 0, 32'h10, 0);
    bus.fetch_ready = 1'b1; bus.stall = 1'b0;
    // mret outside a handler is ignored
    bus.mret = 1'b1;
    expect_cyc("mret_ign", 1, 32'h40,  32'h44,  0, 0, 32'h10, 0);

    // Trap and branch together: trap wins
    bus.trap_req = 1'b1; bus.branch_valid = 1'b1; bus.branch_target = 32'h80;
    expect_cyc("trap_br",  1, 32'h44,  32'h100, 0, 0, 32'h10, 0);
    expect_cyc("tentry3",  0, 32'h100, 32'h100, 1, 1, 32'h44, 0);
    // Trap and mret together inside handler: double fault
    bus.trap_req = 1'b1; bus.mret = 1'b1;
    expect_cyc("dfault",   1, 32'h100, 32'h100, 1, 1, 32'h44, 0);
    bus.branch_valid = 1'b1; bus.branch_target = 32'h40;
    expect_cyc("halt1",    0, 32'h100, 32'h100, 1, 1, 32'h44, 1);
    expect_cyc("halt2",    0, 32'h100, 32'h100, 1, 1, 32'h44, 1);

    // Asynchronous reset between edges
    #2;
    reset = 1'b0;
    #1;
    check_reset_values("rst_async");
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Reboot and check wraparound at the top of the address space
    expect_cyc("boot2",    0, 32'hDEAD_BEE0, 32'h0, 0, 0, 32'h0, 0);
    bus.branch_valid = 1'b1; bus.branch_target = 32'hFFFF_FFFC;
    expect_cyc("br_top",   1, 32'h0,         32'hFFFF_FFFC, 0, 0, 32'h0, 0);
    expect_cyc("wrap",     1, 32'hFFFF_FFFC, 32'h0,         0, 0, 32'h0, 0);
    expect_cyc("post_wr",  1, 32'h0,         32'h4,         0, 0, 32'h0, 0);

    check("sb_drain", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
